// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage_pkg / if_stage
//
// Instruction-fetch stage of an RV32I 5-stage pipeline. Holds the PC, issues
// word fetches over a valid/ready request / valid response instruction-memory
// port (variable, in-order latency) and buffers returned words with their PC
// in a small in-order FIFO. The FIFO head is presented to the IF/ID register.
// An EX-stage redirect reloads the PC, clears the FIFO and marks every fetch
// still in flight as stale so its response is discarded on arrival.
//
// Ports
//   clk             in   clock, all state on rising edge
//   reset           in   asynchronous active-low reset (0 = reset)
//   imem_req_valid  out  fetch request valid
//   imem_req_ready  in   memory accepts the request this cycle
//   imem_req_addr   out  fetch address (current PC, word aligned)
//   imem_rsp_valid  in   instruction word returned (in request order)
//   imem_rsp_data   in   instruction word
//   redirect_valid  in   EX redirects fetch this cycle (taken branch / jump)
//   redirect_pc     in   new fetch PC (bits [1:0] ignored)
//   stall           in   downstream cannot take an instruction this cycle
//   outputs         out  {instr, pc, pc_plus4} of the FIFO head (NOP when empty)
//   outputs_valid   out  outputs holds a real instruction
// -----------------------------------------------------------------------------
package if_stage_pkg;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc_plus4;
   } ifid_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_entry_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

endpackage

module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC        = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH      = 2,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   output ifid_t       outputs,
   output logic        outputs_valid
);

   localparam int CW = $clog2(MAX_OUTSTANDING + 1);                       // outstanding / drop counters
   localparam int IW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1; // in-flight queue pointer
   localparam int FW = $clog2(FIFO_DEPTH);                                // fetch FIFO pointer

   // ---------------------------------------------------------------- state
   logic [31:0]   pc_q,          pc_d;
   logic [CW-1:0] outstanding_q, outstanding_d;
   logic [CW-1:0] drop_cnt_q,    drop_cnt_d;
   logic [IW-1:0] infl_wr_q,     infl_wr_d;
   logic [IW-1:0] infl_rd_q,     infl_rd_d;
   logic [FW-1:0] fifo_wr_q,     fifo_wr_d;
   logic [FW-1:0] fifo_rd_q,     fifo_rd_d;
   logic [FW:0]   fifo_cnt_q,    fifo_cnt_d;

   logic [31:0]   infl_mem [MAX_OUTSTANDING];
   fetch_entry_t  fifo_mem [FIFO_DEPTH];

   // ---------------------------------------------------------------- control
   logic [CW-1:0] live;
   logic          credit_ok;
   logic          accept;
   logic          fifo_push;
   logic          fifo_pop;
   logic [31:0]   popped_pc;
   fetch_entry_t  head;

   function automatic logic [IW-1:0] infl_inc(input logic [IW-1:0] p);
      // In-flight queue depth need not be a power of two, so wrap explicitly.
      return (32'(p) == MAX_OUTSTANDING - 1) ? '0 : p + IW'(1);
   endfunction

   // Fetches that will still produce a FIFO entry; stale ones are excluded.
   assign live      = outstanding_q - drop_cnt_q;
   assign credit_ok = (32'(fifo_cnt_q) + 32'(live)) < FIFO_DEPTH;

   // The request is gated by reset directly so it drops the moment reset
   // asserts, without waiting for a clock edge.
   assign imem_req_valid = reset && !redirect_valid &&
                           (32'(outstanding_q) < MAX_OUTSTANDING) && credit_ok;
   assign imem_req_addr  = pc_q;
   assign accept         = imem_req_valid && imem_req_ready;

   assign popped_pc      = infl_mem[infl_rd_q];
   assign outputs_valid  = (fifo_cnt_q != '0);

   // A redirect discards a same-cycle response and clears the FIFO, so it
   // suppresses both push and pop.
   assign fifo_push = imem_rsp_valid && (drop_cnt_q == '0) && !redirect_valid;
   assign fifo_pop  = outputs_valid && !stall && !redirect_valid;

   // NOTE: every variable assigned in an always_comb gets a default first, so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      pc_d          = pc_q;
      outstanding_d = outstanding_q;
      drop_cnt_d    = drop_cnt_q;
      infl_wr_d     = infl_wr_q;
      infl_rd_d     = infl_rd_q;
      fifo_wr_d     = fifo_wr_q;
      fifo_rd_d     = fifo_rd_q;
      fifo_cnt_d    = fifo_cnt_q;

      if (accept) begin
         pc_d          = pc_q + 32'd4;   // 32-bit wrap is intended
         infl_wr_d     = infl_inc(infl_wr_q);
         outstanding_d = outstanding_d + CW'(1);
      end

      if (imem_rsp_valid) begin
         infl_rd_d     = infl_inc(infl_rd_q);
         outstanding_d = outstanding_d - CW'(1);
         if (drop_cnt_q != '0) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
         end
      end

      if (fifo_push) begin
         fifo_wr_d = fifo_wr_q + FW'(1);
      end
      if (fifo_pop) begin
         fifo_rd_d = fifo_rd_q + FW'(1);
      end
      case ({fifo_push, fifo_pop})
         2'b10:   fifo_cnt_d = fifo_cnt_q + (FW+1)'(1);
         2'b01:   fifo_cnt_d = fifo_cnt_q - (FW+1)'(1);
         default: fifo_cnt_d = fifo_cnt_q;
      endcase

      // Redirect overrides everything above: whatever is still in flight once
      // this cycle's response has retired is stale.
      if (redirect_valid) begin
         pc_d       = redirect_pc & ~32'h3;
         drop_cnt_d = outstanding_d;
         fifo_wr_d  = '0;
         fifo_rd_d  = '0;
         fifo_cnt_d = '0;
      end
   end

   // NOTE: sequential state is written with non-blocking assignments only, so
   // every flop samples the pre-edge value of every other flop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q          <= RESET_PC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
         infl_wr_q     <= '0;
         infl_rd_q     <= '0;
         fifo_wr_q     <= '0;
         fifo_rd_q     <= '0;
         fifo_cnt_q    <= '0;
      end else begin
         pc_q          <= pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
         infl_wr_q     <= infl_wr_d;
         infl_rd_q     <= infl_rd_d;
         fifo_wr_q     <= fifo_wr_d;
         fifo_rd_q     <= fifo_rd_d;
         fifo_cnt_q    <= fifo_cnt_d;
      end
   end

   // NOTE: storage arrays are not reset; the reset pointers and counts
   // guarantee no entry is read before it has been written.
   always_ff @(posedge clk) begin
      if (accept) begin
         infl_mem[infl_wr_q] <= pc_q;
      end
      if (fifo_push) begin
         fifo_mem[fifo_wr_q] <= '{instr: imem_rsp_data, pc: popped_pc};
      end
   end

   // ---------------------------------------------------------------- output
   always_comb begin
      head = fifo_mem[fifo_rd_q];
      if (outputs_valid) begin
         outputs = '{instr: head.instr, pc: head.pc, pc_plus4: head.pc + 32'd4};
      end else begin
         outputs = '{instr: NOP_INSTR, pc: 32'h0, pc_plus4: 32'h4};
      end
   end

   // A response with nothing outstanding is a memory protocol violation.
   rsp_without_request : assert property (
      @(posedge clk) disable iff (!reset) imem_rsp_valid |-> (outstanding_q != '0)
   );

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage
//
// Bench for if_stage. A variable-latency in-order memory model answers every
// accepted fetch. A monitor keeps its own fetch-PC model and a scoreboard of
// the instruction bundles that must come out, in order: a bundle is queued when
// a fetch is accepted and the whole queue is flushed on a redirect. Each bundle
// the DUT hands downstream is compared against the queue head.
// -----------------------------------------------------------------------------
module tb_if_stage;
   import if_stage_pkg::*;

   localparam logic [31:0] RESET_PC   = 32'hFFFF_FFF8;
   localparam ifid_t       NOP_BUNDLE = '{instr: 32'h0000_0013, pc: 32'h0, pc_plus4: 32'h4};

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        stall;
   ifid_t       outputs;
   logic        outputs_valid;

   if_stage #(
      .RESET_PC        (RESET_PC),
      .FIFO_DEPTH      (2),
      .MAX_OUTSTANDING (2)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .stall          (stall),
      .outputs        (outputs),
      .outputs_valid  (outputs_valid)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return {~a[15:0], a[15:0]};
   endfunction

   // ---------------------------------------------------------------- memory model
   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   mreq_t mem_q[$];
   int    mem_lat = 1;
   int    cyc     = 0;

   // Requests are recorded mid-cycle (inputs are stable there) for the coming
   // edge; responses are driven just after the edge of the cycle they are due.
   initial begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            mem_q.delete();
         end else if (imem_req_valid && imem_req_ready) begin
            mem_q.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
         end
         @(posedge clk);
         #1;
         cyc++;
         if (reset && mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(mem_q[0].addr);
            void'(mem_q.pop_front());
         end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
         end
      end
   end

   // ---------------------------------------------------------------- monitor / scoreboard
   ifid_t       sb[$];
   logic [31:0] exp_pc = RESET_PC;

   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            sb.delete();
            exp_pc = RESET_PC;
         end else begin
            if (outputs_valid && !redirect_valid) begin
               if (sb.size() == 0) begin
                  check("sb_underflow", 96'(sb.size()), 96'd1);
               end else begin
                  check(stall ? "head_held" : "deliver", outputs, sb[0]);
                  if (!stall) void'(sb.pop_front());
               end
            end else if (!outputs_valid) begin
               check("empty_nop", outputs, NOP_BUNDLE);
            end

            if (redirect_valid) begin
               check("no_req_on_redirect", 96'(imem_req_valid), 96'd0);
               sb.delete();
               exp_pc = redirect_pc & ~32'h3;
            end else if (imem_req_valid && imem_req_ready) begin
               check("req_addr", imem_req_addr, exp_pc);
               sb.push_back('{instr: instr_of(exp_pc), pc: exp_pc, pc_plus4: exp_pc + 32'd4});
               exp_pc = exp_pc + 32'd4;
            end
         end
      end
   end

   // ---------------------------------------------------------------- stimulus
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Call in the cycle reset is released: request goes out at once, the word
   // returns the next cycle and is visible the cycle after that.
   task automatic check_startup();
      @(negedge clk);
      check("first_req_valid", 96'(imem_req_valid), 96'd1);
      @(negedge clk);
      check("lat_not_yet", 96'(outputs_valid), 96'd0);
      @(negedge clk);
      check("lat_valid", 96'(outputs_valid), 96'd1);
      check("first_pc", outputs.pc, RESET_PC);
   endtask

   initial begin
      logic found;
      reset          = 1'b0;
      imem_req_ready = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      stall          = 1'b0;

      // Reset state
      #2;
      check("rst_req_valid", 96'(imem_req_valid), 96'd0);
      check("rst_out_valid", 96'(outputs_valid), 96'd0);
      check("rst_outputs", outputs, NOP_BUNDLE);
      repeat (2) tick();
      reset = 1'b1;

      // Basic stream from RESET_PC, wrapping through 0
      check_startup();
      repeat (12) tick();

      // Stall mid-stream: FIFO fills, requests stop, head frozen
      stall = 1'b1;
      repeat (5) tick();
      @(negedge clk);
      check("stall_no_req", 96'(imem_req_valid), 96'd0);
      check("stall_valid", 96'(outputs_valid), 96'd1);
      tick();
      stall = 1'b0;
      repeat (10) tick();

      // Latency 3, two fetches in flight, redirect to 0x100
      mem_lat = 3;
      found   = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         #1;
         if (mem_q.size() == 2 && !imem_rsp_valid) found = 1'b1;
      end
      check("k3_two_outstanding", 96'(found), 96'd1);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0100;
      tick();
      redirect_valid = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         if (imem_req_valid) found = 1'b1;
      end
      check("redir_req_seen", 96'(found), 96'd1);
      check("redir_addr", imem_req_addr, 32'h0000_0100);
      repeat (15) tick();

      // Redirect coinciding with a response while stalled with a non-empty FIFO
      mem_lat = 2;
      stall   = 1'b1;
      found   = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         #1;
         if (imem_rsp_valid && outputs_valid) found = 1'b1;
      end
      check("rsp_with_head_seen", 96'(found), 96'd1);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0203;   // low bits must be ignored
      tick();
      redirect_valid = 1'b0;
      @(negedge clk);
      check("flush_empty", 96'(outputs_valid), 96'd0);
      tick();
      stall = 1'b0;
      repeat (15) tick();

      // Memory not ready: address held, nothing new outstanding
      imem_req_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("hold_addr", imem_req_addr, exp_pc);
      end
      check("hold_req_valid", 96'(imem_req_valid), 96'd1);
      check("hold_no_outstanding", 96'(mem_q.size()), 96'd0);
      tick();
      imem_req_ready = 1'b1;
      repeat (15) tick();

      // Async reset mid-stream: outputs drop with no clock edge
      mem_lat = 1;
      tick();
      #2;
      reset = 1'b0;
      #1;
      check("async_out_valid", 96'(outputs_valid), 96'd0);
      check("async_req_valid", 96'(imem_req_valid), 96'd0);
      repeat (2) tick();
      reset = 1'b1;
      check_startup();
      repeat (10) tick();

      // Random traffic: ready, stall, redirects and latency all varying
      for (int i = 0; i < 300; i++) begin
         if (i % 40 == 0) mem_lat = $urandom_range(1, 3);
         imem_req_ready = ($urandom_range(0, 3) != 0);
         stall          = ($urandom_range(0, 3) == 0);
         redirect_valid = ($urandom_range(0, 15) == 0);
         redirect_pc    = $urandom;
         tick();
      end

      // Drain
      redirect_valid = 1'b0;
      stall          = 1'b0;
      imem_req_ready = 1'b0;
      found          = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         tick();
         if (sb.size() == 0 && mem_q.size() == 0 && !outputs_valid) found = 1'b1;
      end
      check("drain_done", 96'(found), 96'd1);
      check("drain_sb_empty", 96'(sb.size()), 96'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
